// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode encoding and the 3-bit FSM state encoding
// used by both ends of the half-duplex link.
package uart_pkg;

    localparam logic [1:0] UART_PAR_NONE = 2'b00;
    localparam logic [1:0] UART_PAR_EVEN = 2'b01;
    localparam logic [1:0] UART_PAR_ODD  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_state_e;

    // The reserved code 2'b11 behaves like "no parity".
    function automatic logic par_enabled(input logic [1:0] mode);
        return (mode == UART_PAR_EVEN) || (mode == UART_PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Line-side and byte-side signals of the UART frame receiver.
// master = the host/line driver, slave = the receiver.
interface uart_rx_frame_if;
    logic       rx;
    logic [1:0] rx_mode;
    logic [7:0] dout;
    logic       done;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    modport master (
        output rx, rx_mode,
        input  dout, done, parity_err, frame_err, busy
    );

    modport slave (
        input  rx, rx_mode,
        output dout, done, parity_err, frame_err, busy
    );
endinterface

// File: rtl/uart_sync2.sv
// Generic 2-flop synchronizer for asynchronous single-bit inputs; both flops
// load RST_VAL on a synchronous active-low reset.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx_frame.sv
// UART frame receiver: start-bit validation, 8 data bits LSB-first sampled at
// mid-bit, optional parity, stop check, and a one-cycle done strobe with flags.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic            clk,
    input  logic            rst,
    uart_rx_frame_if.slave  bus
);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    uart_state_e   state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [1:0]    mode_q;
    logic          perr_q;
    logic          rx_s;
    logic          par_exp;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.rx),
        .q   (rx_s)
    );

    assign par_exp = (^shreg) ^ (mode_q == UART_PAR_ODD);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            bit_idx        <= '0;
            shreg          <= '0;
            mode_q         <= UART_PAR_NONE;
            perr_q         <= 1'b0;
            bus.dout       <= 8'h00;
            bus.done       <= 1'b0;
            bus.parity_err <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            bus.done       <= 1'b0;
            bus.parity_err <= 1'b0;
            bus.frame_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt    <= '0;
                    mode_q <= bus.rx_mode;
                    perr_q <= 1'b0;
                    if (!rx_s) begin
                        state    <= ST_START;
                        bus.busy <= 1'b1;
                    end
                end
                ST_START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        // A line that is high again at mid-start was only a glitch.
                        if (rx_s) begin
                            state    <= ST_IDLE;
                            bus.busy <= 1'b0;
                        end else begin
                            state   <= ST_DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt            <= '0;
                        shreg[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7)
                            state <= par_enabled(mode_q) ? ST_PARITY : ST_STOP;
                        else
                            bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt    <= '0;
                        perr_q <= (rx_s != par_exp);
                        state  <= ST_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt            <= '0;
                        bus.dout       <= shreg;
                        bus.done       <= 1'b1;
                        bus.parity_err <= perr_q;
                        bus.frame_err  <= ~rx_s;
                        // A low stop bit parks in BREAK so a held-low line cannot retrigger.
                        if (rx_s) begin
                            state    <= ST_IDLE;
                            bus.busy <= 1'b0;
                        end else begin
                            state <= ST_BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (rx_s) begin
                        state    <= ST_IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: frames are driven bit-serially on negedges
// and a monitor records every done cycle with the byte and flags seen with it.
module tb_uart_rx_frame;
    localparam int C = 16;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   cyc;
    int   t0;
    int   done_cnt;
    int   done_cyc  [0:63];
    logic [7:0] cap_dout [0:63];
    logic cap_perr [0:63];
    logic cap_ferr [0:63];

    uart_rx_frame_if bus_if ();

    uart_rx_frame #(.CLKS_PER_BIT(C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (bus_if.done === 1'b1) begin
            if (done_cnt < 64) begin
                done_cyc[done_cnt] = cyc;
                cap_dout[done_cnt] = bus_if.dout;
                cap_perr[done_cnt] = bus_if.parity_err;
                cap_ferr[done_cnt] = bus_if.frame_err;
            end
            done_cnt = done_cnt + 1;
        end
    end

    // Caller must be at a negedge; returns at a negedge right after the stop bit.
    task automatic send_frame(input logic [7:0] data, input logic par_en,
                              input logic par_bit, input logic stop_bit);
        bus_if.rx = 1'b0;
        t0 = cyc + 1;
        for (int i = 0; i < 8; i++) begin
            repeat (C) @(negedge clk);
            bus_if.rx = data[i];
        end
        if (par_en) begin
            repeat (C) @(negedge clk);
            bus_if.rx = par_bit;
        end
        repeat (C) @(negedge clk);
        bus_if.rx = stop_bit;
        repeat (C) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus_if.rx = 1'b1;
        bus_if.rx_mode = 2'b00;
        repeat (3) @(negedge clk);
        tests++;
        if (bus_if.dout !== 8'h00) begin fails++; $display("FAIL reset_dout got %h exp 00", bus_if.dout); end
        tests++;
        if ({bus_if.done, bus_if.parity_err, bus_if.frame_err, bus_if.busy} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags got %b exp 0000", {bus_if.done, bus_if.parity_err, bus_if.frame_err, bus_if.busy});
        end
        rst = 1'b1;
        repeat (5) @(negedge clk);
        tests++;
        if (bus_if.busy !== 1'b0 || done_cnt !== 0) begin
            fails++; $display("FAIL idle_after_reset busy %b done_cnt %0d exp 0 0", bus_if.busy, done_cnt);
        end
    endtask

    task automatic test_even_parity();
        int n0;
        n0 = done_cnt;
        bus_if.rx_mode = 2'b01;
        send_frame(8'hC3, 1'b1, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        tests++;
        if (done_cnt !== n0 + 1) begin fails++; $display("FAIL even_done_count got %0d exp %0d", done_cnt - n0, 1); end
        tests++;
        if (done_cyc[n0] - t0 !== 170) begin fails++; $display("FAIL even_done_edge got %0d exp 170", done_cyc[n0] - t0); end
        tests++;
        if ({cap_dout[n0], cap_perr[n0], cap_ferr[n0]} !== {8'hC3, 2'b00}) begin
            fails++; $display("FAIL even_data got %h/%b/%b exp c3/0/0", cap_dout[n0], cap_perr[n0], cap_ferr[n0]);
        end
        tests++;
        if (bus_if.done !== 1'b0 || bus_if.dout !== 8'hC3) begin
            fails++; $display("FAIL even_hold done %b dout %h exp 0 c3", bus_if.done, bus_if.dout);
        end
    endtask

    task automatic test_odd_parity();
        int n0;
        n0 = done_cnt;
        bus_if.rx_mode = 2'b10;
        send_frame(8'hC1, 1'b1, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        send_frame(8'hC1, 1'b1, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        tests++;
        if (done_cnt !== n0 + 2) begin fails++; $display("FAIL odd_done_count got %0d exp 2", done_cnt - n0); end
        tests++;
        if ({cap_dout[n0], cap_perr[n0], cap_ferr[n0]} !== {8'hC1, 2'b00}) begin
            fails++; $display("FAIL odd_good got %h/%b/%b exp c1/0/0", cap_dout[n0], cap_perr[n0], cap_ferr[n0]);
        end
        tests++;
        if ({cap_dout[n0+1], cap_perr[n0+1], cap_ferr[n0+1]} !== {8'hC1, 2'b10}) begin
            fails++; $display("FAIL odd_bad got %h/%b/%b exp c1/1/0", cap_dout[n0+1], cap_perr[n0+1], cap_ferr[n0+1]);
        end
    endtask

    task automatic test_stop_error();
        int n0;
        n0 = done_cnt;
        bus_if.rx_mode = 2'b00;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        repeat (24) @(negedge clk);
        tests++;
        if (done_cnt !== n0 + 1 || bus_if.busy !== 1'b1) begin
            fails++; $display("FAIL stop_break done_count %0d busy %b exp 1 1", done_cnt - n0, bus_if.busy);
        end
        tests++;
        if ({cap_dout[n0], cap_perr[n0], cap_ferr[n0]} !== {8'h5A, 2'b01}) begin
            fails++; $display("FAIL stop_flags got %h/%b/%b exp 5a/0/1", cap_dout[n0], cap_perr[n0], cap_ferr[n0]);
        end
        bus_if.rx = 1'b1;
        repeat (10) @(negedge clk);
        tests++;
        if (done_cnt !== n0 + 1 || bus_if.busy !== 1'b0) begin
            fails++; $display("FAIL stop_release done_count %0d busy %b exp 1 0", done_cnt - n0, bus_if.busy);
        end
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        tests++;
        if (done_cnt !== n0 + 2 || cap_dout[n0+1] !== 8'hA5 || cap_ferr[n0+1] !== 1'b0) begin
            fails++; $display("FAIL stop_recover count %0d dout %h ferr %b exp 2 a5 0", done_cnt - n0, cap_dout[n0+1], cap_ferr[n0+1]);
        end
    endtask

    task automatic test_glitch();
        int n0;
        n0 = done_cnt;
        bus_if.rx_mode = 2'b00;
        bus_if.rx = 1'b0;
        t0 = cyc + 1;
        repeat (4) @(negedge clk);
        bus_if.rx = 1'b1;
        tests++;
        if (bus_if.busy !== 1'b1) begin fails++; $display("FAIL glitch_start busy %b exp 1", bus_if.busy); end
        repeat (8) @(negedge clk);
        tests++;
        if (bus_if.busy !== 1'b0) begin fails++; $display("FAIL glitch_busy_edge11 busy %b exp 0 (cyc %0d)", bus_if.busy, cyc - t0); end
        repeat (30) @(negedge clk);
        tests++;
        if (done_cnt !== n0) begin fails++; $display("FAIL glitch_no_done count %0d exp 0", done_cnt - n0); end
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        tests++;
        if (done_cnt !== n0 + 1 || cap_dout[n0] !== 8'h3C || done_cyc[n0] - t0 !== 154) begin
            fails++; $display("FAIL glitch_next count %0d dout %h edge %0d exp 1 3c 154", done_cnt - n0, cap_dout[n0], done_cyc[n0] - t0);
        end
    endtask

    task automatic test_reset_midframe();
        int n0;
        n0 = done_cnt;
        bus_if.rx_mode = 2'b00;
        fork
            send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
            begin
                repeat (66) @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                tests++;
                if (bus_if.busy !== 1'b0 || bus_if.dout !== 8'h00) begin
                    fails++; $display("FAIL midreset_state busy %b dout %h exp 0 00", bus_if.busy, bus_if.dout);
                end
            end
        join
        repeat (10) @(negedge clk);
        tests++;
        if (done_cnt !== n0) begin fails++; $display("FAIL midreset_no_done count %0d exp 0", done_cnt - n0); end
        send_frame(8'h81, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        tests++;
        if (done_cnt !== n0 + 1 || cap_dout[n0] !== 8'h81) begin
            fails++; $display("FAIL midreset_next count %0d dout %h exp 1 81", done_cnt - n0, cap_dout[n0]);
        end
    endtask

    task automatic test_back_to_back();
        int n0;
        int t_first;
        n0 = done_cnt;
        bus_if.rx_mode = 2'b00;
        send_frame(8'h01, 1'b0, 1'b0, 1'b1);
        t_first = t0;
        send_frame(8'h80, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        tests++;
        if (done_cnt !== n0 + 2) begin fails++; $display("FAIL b2b_count got %0d exp 2", done_cnt - n0); end
        tests++;
        if (cap_dout[n0] !== 8'h01 || cap_dout[n0+1] !== 8'h80) begin
            fails++; $display("FAIL b2b_data got %h %h exp 01 80", cap_dout[n0], cap_dout[n0+1]);
        end
        tests++;
        if (done_cyc[n0] - t_first !== 154 || done_cyc[n0+1] - done_cyc[n0] !== 160) begin
            fails++; $display("FAIL b2b_timing first %0d gap %0d exp 154 160", done_cyc[n0] - t_first, done_cyc[n0+1] - done_cyc[n0]);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        cyc = 0;
        done_cnt = 0;
        t0 = 0;
        rst = 1'b0;
        bus_if.rx = 1'b1;
        bus_if.rx_mode = 2'b00;
        @(negedge clk);
        test_reset();
        test_even_parity();
        repeat (20) @(negedge clk);
        test_odd_parity();
        repeat (20) @(negedge clk);
        test_stop_error();
        repeat (20) @(negedge clk);
        test_glitch();
        repeat (20) @(negedge clk);
        test_reset_midframe();
        repeat (20) @(negedge clk);
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Serial receiver for the half-duplex UART link: the far-end counterpart of `uart_half_duplex`. It synchronizes the asynchronous `rx` line, detects and validates a start bit, and samples 8 data bits LSB-first at mid-bit. It then checks an optional parity bit and the stop bit, and presents the byte on `dout` with a one-cycle `done` strobe plus error flags. Its parity mode encoding matches the transmitter's `tx_mode`, so one mode value configures both ends of the link.

## Interface
- `CLKS_PER_BIT`, default 16: `clk` cycles per serial bit. Must be an even number ≥ 4.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `rx`  in  1  serial line, asynchronous. Idle level is 1.
- `rx_mode`  in  2  parity mode: 00 = none, 01 = even, 10 = odd, 11 = reserved (treated as none).
- `dout`  out  8  last received byte. Holds its value until the next frame completes.
- `done`  out  1  one-cycle pulse when a frame completes (stop bit sampled).
- `parity_err`  out  1  valid with `done`; high when parity mismatched.
- `frame_err`  out  1  valid with `done`; high when the stop bit sampled 0.
- `busy`  out  1  high in every state except IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer, reset to 1. The FSM sees only `rx_s`, the synchronized value.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- **IDLE:** `rx_s` = 0 moves to START. The bit counter `cnt` clears to 0. `rx_mode` is latched as `mode_q` and stays fixed for the whole frame.
- **START:** `cnt` counts up. When `cnt` = `CLKS_PER_BIT`/2−1, `rx_s` is sampled:
  - `rx_s` = 1 → false start. Return to IDLE with no `done`.
  - `rx_s` = 0 → go to DATA with `cnt` = 0 and `bit_idx` = 0.
- **DATA:** sample when `cnt` = `CLKS_PER_BIT`−1. The sample shifts into `shreg[bit_idx]` (LSB first). After `bit_idx` = 7, go to PARITY if `mode_q` ∈ {01, 10}, otherwise go to STOP.
- **PARITY:** sample at `cnt` = `CLKS_PER_BIT`−1.
  - Expected bit is XOR of the data for even mode, or its inverse for odd mode.
  - A mismatch sets the internal flag `perr_q`.
- **STOP:** sample at `cnt` = `CLKS_PER_BIT`−1. On that edge:
  - `dout` ← `shreg`
  - `done` ← 1
  - `parity_err` ← `perr_q`
  - `frame_err` ← ~`rx_s`
  - Next state is IDLE if `rx_s` = 1, or BREAK if `rx_s` = 0.
- **BREAK:** wait for `rx_s` = 1, then go to IDLE. This prevents a held-low line from retriggering frames.
- `done`, `parity_err`, and `frame_err` are all cleared on the cycle after the pulse. The byte is delivered to `dout` even when an error flag is set.
- **Reset:** when `rst` = 0 on any edge, including mid-frame:
  - FSM goes to IDLE.
  - `cnt`, `bit_idx`, `shreg`, and `perr_q` clear to 0.
  - Synchronizer flops go to 1.
  - `dout` = 0x00; `done`, `parity_err`, `frame_err`, and `busy` = 0.
  - Any partial frame is discarded with no `done`.

## Timing
- Cycle 0 is the first edge at which the synchronizer input samples `rx` = 0. The FSM enters START at edge 2.
- The start bit is sampled at edge 2 + C/2, where C = `CLKS_PER_BIT`.
- Data bit k is sampled at edge 2 + C/2 + (k+1)·C.
- P = 1 when parity is enabled, otherwise 0.
- `done` is high for exactly the one cycle following edge 2 + C/2 + (9+P)·C:
  - C = 16, P = 0 → edge 154.
  - C = 16, P = 1 → edge 170.
- Back-to-back frames: a start edge arriving one `clk` after the stop sample is accepted. There is no dead time beyond the IDLE cycle.
- `busy` is registered. It goes high with the START entry and low with the IDLE entry.
- A low pulse on `rx` shorter than C/2 − 1 cycles is always rejected as a false start.

## Structure
- Shared package `uart_pkg` holds:
  - the `rx_mode`/`tx_mode` constants `UART_PAR_NONE` = 2'b00, `UART_PAR_EVEN` = 2'b01, `UART_PAR_ODD` = 2'b10;
  - the 3-bit state encoding constants, used by both `uart_half_duplex` and this block.
- One sub-module is used: `uart_sync2`, a generic 2-flop synchronizer with a reset value parameter. It is reused on other async inputs.
- The counter, FSM, and datapath live in `uart_rx_frame`.

## Test plan
- **Even parity:** C = 16, `rx_mode` = 01, send 0xC3 (parity bit 0, stop 1) → `dout` = 0xC3, `done` pulse at edge 170, `parity_err` = 0, `frame_err` = 0.
- **Odd parity:** `rx_mode` = 10, send 0xC1 with parity bit 0 → `dout` = 0xC1, no errors. Repeat with parity bit 1 → `dout` = 0xC1, `parity_err` = 1.
- **Stop-bit error:** `rx_mode` = 00, send 0x5A with stop bit 0 and the line held low for 40 cycles → `done` with `frame_err` = 1 and `dout` = 0x5A. No second `done` until the line rises and a new start bit arrives.
- **Glitch rejection:** 4-cycle low glitch on idle `rx` → no `done`, `busy` returns to 0 by edge 11, the next valid frame 0x3C is received correctly.
- **Reset mid-frame:** `rst` = 0 for one cycle during DATA bit 3 of 0xFF → `busy` = 0 and `dout` = 0x00 on the next edge, no `done`. The following frame 0x81 is received correctly.
- **Back-to-back frames:** 0x01 then 0x80 with no idle gap, `rx_mode` = 00 → two `done` pulses 160 cycles apart with `dout` = 0x01 then 0x80.
